// File: rtl/temp_guard.sv
// Temperature zone guard: debounced four-zone status with downward hysteresis,
// plus sticky alarms for HOT entry and a persistently inverted sensor.
module temp_guard #(
  parameter int WIDTH     = 8,
  parameter int T_LO      = 20,
  parameter int T_MID     = 40,
  parameter int T_HI      = 60,
  parameter int HYST      = 2,
  parameter int DEB       = 3,
  parameter int FLIP_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             temp_valid,
  input  logic [WIDTH-1:0] temp,
  input  logic             flip,
  input  logic             alert_clr,
  output logic [1:0]       status,
  output logic             flip_alert,
  output logic             hot_alert
);

  localparam logic [WIDTH-1:0] L_LO   = T_LO[WIDTH-1:0];
  localparam logic [WIDTH-1:0] L_MID  = T_MID[WIDTH-1:0];
  localparam logic [WIDTH-1:0] L_HI   = T_HI[WIDTH-1:0];
  localparam logic [WIDTH:0]   L_HYST = HYST[WIDTH:0];
  localparam logic [3:0]       L_DEB  = DEB[3:0];
  localparam logic [3:0]       L_FH   = FLIP_HOLD[3:0];

  logic [1:0] r_status, r_pend;
  logic [3:0] r_cnt, r_fcnt;
  logic       r_flip_alert, r_hot_alert;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_sat;
  logic [1:0]       w_cls_t, w_cls_h, w_cand;
  logic [1:0]       w_status_nxt, w_pend_nxt;
  logic [3:0]       w_cnt_nxt, w_cnt_inc;
  logic             w_sample, w_flip_hit, w_hot_set;

  function automatic logic [1:0] f_class(input logic [WIDTH-1:0] v);
    if (v < L_LO)       return 2'd0;
    else if (v < L_MID) return 2'd1;
    else if (v < L_HI)  return 2'd2;
    else                return 2'd3;
  endfunction

  // Falling out of a zone requires the sample to clear it by HYST, so the
  // downward decision uses temp+HYST (saturated) rather than temp itself.
  assign w_sum    = {1'b0, temp} + L_HYST;
  assign w_sat    = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
  assign w_cls_t  = f_class(temp);
  assign w_cls_h  = f_class(w_sat);
  assign w_cand   = (w_cls_t > r_status) ? w_cls_t :
                    (w_cls_h < r_status) ? w_cls_h : r_status;
  assign w_sample = temp_valid & ~flip;

  always_comb begin
    w_pend_nxt   = r_pend;
    w_cnt_nxt    = r_cnt;
    w_cnt_inc    = '0;
    w_status_nxt = r_status;
    if (w_sample) begin
      if (w_cand == r_status) begin
        w_cnt_nxt = '0;
      end else begin
        if (w_cand == r_pend) begin
          w_cnt_inc = r_cnt + 4'd1;
        end else begin
          w_pend_nxt = w_cand;
          w_cnt_inc  = 4'd1;
        end
        if (w_cnt_inc >= L_DEB) begin
          w_status_nxt = w_pend_nxt;
          w_cnt_nxt    = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
    end
  end

  assign w_flip_hit = flip & (r_fcnt == L_FH - 4'd1);
  assign w_hot_set  = (w_status_nxt == 2'd3) & (r_status != 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_status     <= '0;
      r_pend       <= '0;
      r_cnt        <= '0;
      r_fcnt       <= '0;
      r_flip_alert <= 1'b0;
      r_hot_alert  <= 1'b0;
    end else begin
      r_status <= w_status_nxt;
      r_pend   <= w_pend_nxt;
      r_cnt    <= w_cnt_nxt;
      if (flip) r_fcnt <= (r_fcnt == L_FH) ? r_fcnt : r_fcnt + 4'd1;
      else      r_fcnt <= '0;
      // Sets win over a coincident clear on both alarms.
      if (w_flip_hit)              r_flip_alert <= 1'b1;
      else if (alert_clr && !flip) r_flip_alert <= 1'b0;
      if (w_hot_set)               r_hot_alert  <= 1'b1;
      else if (alert_clr)          r_hot_alert  <= 1'b0;
    end
  end

  assign status     = r_status;
  assign flip_alert = r_flip_alert;
  assign hot_alert  = r_hot_alert;

endmodule

// File: tb/tb_temp_guard.sv
// Scoreboard bench for temp_guard: DEB=3 and DEB=1 instances share stimulus,
// expected outputs are queued per driven cycle and popped after the edge.
module tb_temp_guard;

  logic       clk = 1'b0;
  logic       reset = 1'b1, temp_valid = 1'b0, flip = 1'b0, alert_clr = 1'b0;
  logic [7:0] temp = '0;
  logic [1:0] st0, st1;
  logic       fa0, fa1, hot0, hot1;

  int n_run = 0, n_fail = 0;

  typedef struct {int st0; int hot0; int st1; int hot1; int fa;} exp_t;
  exp_t sb_q[$];

  int m_st[2], m_pend[2], m_cnt[2], m_hot[2];
  int m_deb[2] = '{3, 1};
  int m_fc, m_fa;

  always #5 clk = ~clk;

  temp_guard #(.DEB(3)) u_dut0 (
    .clk(clk), .reset(reset), .temp_valid(temp_valid), .temp(temp), .flip(flip),
    .alert_clr(alert_clr), .status(st0), .flip_alert(fa0), .hot_alert(hot0));

  temp_guard #(.DEB(1)) u_dut1 (
    .clk(clk), .reset(reset), .temp_valid(temp_valid), .temp(temp), .flip(flip),
    .alert_clr(alert_clr), .status(st1), .flip_alert(fa1), .hot_alert(hot1));

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int cls(input int v);
    if (v < 20) return 0;
    if (v < 40) return 1;
    if (v < 60) return 2;
    return 3;
  endfunction

  task automatic model(input bit v, input int t, input bit f, input bit c, input bit r);
    int cz, ch, cand, ns;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_st[k] = 0; m_pend[k] = 0; m_cnt[k] = 0; m_hot[k] = 0;
      end else begin
        cz   = cls(t);
        ch   = cls((t + 2 > 255) ? 255 : t + 2);
        cand = (cz > m_st[k]) ? cz : ((ch < m_st[k]) ? ch : m_st[k]);
        ns   = m_st[k];
        if (v && !f) begin
          if (cand == m_st[k]) m_cnt[k] = 0;
          else begin
            if (cand == m_pend[k]) m_cnt[k]++;
            else begin m_pend[k] = cand; m_cnt[k] = 1; end
            if (m_cnt[k] == m_deb[k]) begin ns = m_pend[k]; m_cnt[k] = 0; end
          end
        end
        if (ns == 3 && m_st[k] != 3) m_hot[k] = 1;
        else if (c)                  m_hot[k] = 0;
        m_st[k] = ns;
      end
    end
    if (r) begin
      m_fc = 0; m_fa = 0;
    end else if (f) begin
      if (m_fc == 3) m_fa = 1;
      if (m_fc < 4) m_fc++;
    end else begin
      m_fc = 0;
      if (c) m_fa = 0;
    end
  endtask

  task automatic step(input bit v, input int t, input bit f, input bit c, input bit r);
    exp_t e;
    temp_valid = v; temp = t[7:0]; flip = f; alert_clr = c; reset = r;
    model(v, t, f, c, r);
    sb_q.push_back('{m_st[0], m_hot[0], m_st[1], m_hot[1], m_fa});
    @(posedge clk); #1;
    e = sb_q.pop_front();
    chk("status0", st0, e.st0);
    chk("hot0", hot0, e.hot0);
    chk("flip0", fa0, e.fa);
    chk("status1", st1, e.st1);
    chk("hot1", hot1, e.hot1);
    chk("flip1", fa1, e.fa);
  endtask

  initial begin
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("rst_status", st0, 0); chk("rst_hot", hot0, 0); chk("rst_flip", fa0, 0);

    repeat (2) step(1, 45, 0, 0, 0);
    chk("warm_wait", st0, 0);
    step(1, 45, 0, 0, 0);
    chk("warm_enter", st0, 2);
    step(1, 45, 0, 0, 0); step(1, 45, 0, 0, 0); step(1, 10, 0, 0, 0);
    chk("warm_hold", st0, 2);

    repeat (3) step(1, 39, 0, 0, 0);
    chk("hyst_hold", st0, 2);
    repeat (3) step(1, 37, 0, 0, 0);
    chk("hyst_drop", st0, 1);

    repeat (3) step(1, 70, 0, 0, 0);
    chk("hot_status", st0, 3); chk("hot_set", hot0, 1);
    step(0, 0, 0, 1, 0);
    chk("hot_clr", hot0, 0); chk("hot_keep_st", st0, 3);

    repeat (3) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("flip_short", fa0, 0);
    repeat (3) step(0, 0, 1, 0, 0);
    chk("flip_pre", fa0, 0);
    step(0, 0, 1, 0, 0);
    chk("flip_set", fa0, 1);
    step(0, 0, 1, 1, 0);
    chk("flip_clr_blk", fa0, 1);
    step(0, 0, 0, 1, 0);
    chk("flip_clr", fa0, 0);
    repeat (4) step(1, 10, 1, 0, 0);
    chk("flip_gate_cold", st0, 3);
    step(1, 70, 1, 0, 0);
    chk("flip_gate_hot", st0, 3);

    step(0, 0, 0, 0, 1);
    repeat (2) step(1, 50, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(1, 50, 0, 0, 0);
    chk("rst_mid_deb", st0, 0);

    step(0, 0, 0, 0, 1);
    step(1, 50, 0, 0, 0);
    chk("deb1_follow", st1, 2);
    step(0, 50, 0, 0, 0); step(1, 50, 0, 0, 0); step(0, 50, 0, 0, 0);
    chk("gap_wait", st0, 0);
    step(1, 50, 0, 0, 0);
    chk("gap_enter", st0, 2);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 90), $urandom_range(0, 5) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 60) == 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/temp_guard.md
TEMP_GUARD -- requirements
Module: temp_guard

Interface
REQ-001 SHALL have parameter WIDTH, default 8, temperature sample width in bits (4..16).
REQ-002 SHALL have parameter T_LO, default 20, lower zone threshold.
REQ-003 SHALL have parameter T_MID, default 40, middle zone threshold.
REQ-004 SHALL have parameter T_HI, default 60, upper zone threshold (T_LO < T_MID < T_HI < 2^WIDTH).
REQ-005 SHALL have parameter HYST, default 2, downward hysteresis margin.
REQ-006 SHALL have parameter DEB, default 3, consecutive qualifying samples before a status change (1..15).
REQ-007 SHALL have parameter FLIP_HOLD, default 4, consecutive flip-high cycles that raise flip_alert (1..15).
REQ-008 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-009 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-010 SHALL have port temp_valid, input, 1, qualifies temp in the current cycle.
REQ-011 SHALL have port temp, input, WIDTH, unsigned temperature sample.
REQ-012 SHALL have port flip, input, 1, sensor-inverted indication.
REQ-013 SHALL have port alert_clr, input, 1, clear request for the sticky alerts.
REQ-014 SHALL have port status, output, 2, current zone: 0 COLD, 1 NORMAL, 2 WARM, 3 HOT (registered).
REQ-015 SHALL have port flip_alert, output, 1, sticky flip alarm (registered).
REQ-016 SHALL have port hot_alert, output, 1, sticky HOT-entry alarm (registered).

Function
REQ-017 SHALL classify a value v as class(v) = 0 if v<T_LO, 1 if v<T_MID, 2 if v<T_HI, else 3.
REQ-018 SHALL derive the candidate zone: if class(temp) > status, class(temp); else if class(sat(temp+HYST)) < status, class(sat(temp+HYST)); else status. sat() saturates at 2^WIDTH-1.
REQ-019 SHALL treat a cycle as a sample only when temp_valid=1 and flip=0.
REQ-020 SHALL keep a pending zone and a debounce counter: on a sample with candidate = status, the counter clears.
REQ-021 SHALL, on a sample with candidate != status, set counter to count+1 if candidate = pending, else pending := candidate and counter := 1.
REQ-022 SHALL load status := pending on the edge at which the counter reaches DEB; the counter then clears. Multi-zone jumps (e.g. 0->3) are allowed in one change.
REQ-023 SHALL hold pending and counter unchanged on non-sample cycles.
REQ-024 SHALL count consecutive cycles with flip=1 (independent of temp_valid), saturating at FLIP_HOLD; flip=0 clears the count.
REQ-025 SHALL set flip_alert on the edge at which the flip count reaches FLIP_HOLD.
REQ-026 SHALL clear flip_alert when alert_clr=1 and flip=0; alert_clr with flip=1 leaves flip_alert unchanged.
REQ-027 SHALL set hot_alert on the edge at which status changes to 3; alert_clr=1 clears it otherwise.
REQ-028 SHALL give set priority over clear when a set and alert_clr coincide on either alert.
REQ-029 SHALL leave status unaffected by alert_clr.

Reset
REQ-030 SHALL, when reset=1 at an edge, set status=0, flip_alert=0, hot_alert=0, pending=0, debounce counter=0 and flip count=0, overriding all other inputs including a change in progress.

Verification
REQ-031 SHALL cover: reset; temp=45 valid for 3 cycles -> status 0 to 2 after the 3rd edge. Then temp=45, 45, 10 -> status stays 2.
REQ-032 SHALL cover hysteresis: status=2; temp=39 for 3 samples -> status stays 2. Then temp=37 for 3 samples -> status=1.
REQ-033 SHALL cover: temp=70 for 3 samples -> status=3, hot_alert=1. Then a 1-cycle alert_clr -> hot_alert=0, status stays 3.
REQ-034 SHALL cover flip: flip=1 for 3 cycles then 0 -> flip_alert stays 0. flip=1 for 4 cycles -> flip_alert=1 after the 4th edge. alert_clr with flip=1 -> flip_alert stays 1. alert_clr with flip=0 -> flip_alert=0. temp=70 valid during flip=1 -> status unchanged.
REQ-035 SHALL cover reset mid-debounce: 2 samples of 50, then reset, then 1 sample of 50 -> status remains 0.
REQ-036 SHALL cover gaps: 50, invalid, 50, invalid, 50 -> status=2 after the 3rd valid sample's edge. Also DEB=1 -> status follows a crossing sample after one edge.
